mem_access: RTL and testbench

Pipeline MEM1 stage, directly downstream of the execute stage. It consumes the EX/MEM1 pipeline registers, performs alignment checks, and issues load/store transactions on the data bus with a req/ack handshake. It formats store data and byte selects, and extracts and extends load data. It registers the result into the MEM1/MEM2 pipeline registers, and requests a pipeline stall while a bus transaction is outstanding.

---
 rtl/mem_access.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM1 pipeline stage: alignment checks, data bus req/ack handshake,
// store formatting, load extraction and the MEM1/MEM2 registers.
package mem_access_pkg;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU,
    MEM_LW, MEM_SB, MEM_SH, MEM_SW
  } mem_oper_t;

  typedef enum logic [3:0] {
    NO_TRAP,
    INSTR_ADDR_MISALIGNED,
    ILLEGAL_INSTR,
    LOAD_ADDR_MISALIGNED,
    STORE_ADDR_MISALIGNED,
    ECALL_M
  } exc_t;
endpackage

module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_oper2_i,
  input  mem_oper_t   mem_oper_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [11:0] csr_waddr_i,
  input  logic        csr_we_i,
  input  logic        is_csr_i,
  input  exc_t        trap_i,
  input  logic        instr_valid_i,
  input  logic        write_rd_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_wsel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        stall_req_o,
  output logic [31:0] rd_data_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [11:0] csr_waddr_o,
  output logic        csr_we_o,
  output logic        is_csr_o,
  output exc_t        trap_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        write_rd_o,
  output logic [4:0]  rd_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_DONE, S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic        is_load, is_store;
  logic        is_half, is_word;
  logic        misalign, mem_op;
  logic        access_en, mis_trap;
  logic [3:0]  wsel_c;
  logic [31:0] wdata_c;
  logic        req_c, stall_c, cap_c;

  logic        we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wsel_q;

  logic [31:0] word, shifted, load_val;
  logic [31:0] rd_data_d;
  exc_t        trap_d;
  logic        write_rd_d;

  logic [31:0] pc_q, rd_data_q, mem_addr_q;
  logic [31:0] csr_wdata_q;
  logic [11:0] csr_waddr_q;
  logic        csr_we_q, is_csr_q;
  exc_t        trap_q;
  logic        valid_q, write_rd_q;
  logic [4:0]  rd_addr_q;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    unique case (mem_oper_i)
      MEM_LB, MEM_LBU: is_load = 1'b1;
      MEM_LH, MEM_LHU: begin
        is_load = 1'b1;
        is_half = 1'b1;
      end
      MEM_LW: begin
        is_load = 1'b1;
        is_word = 1'b1;
      end
      MEM_SB: is_store = 1'b1;
      MEM_SH: begin
        is_store = 1'b1;
        is_half  = 1'b1;
      end
      MEM_SW: begin
        is_store = 1'b1;
        is_word  = 1'b1;
      end
      default: ;
    endcase
  end

  assign misalign = (is_half & alu_result_i[0])
                  | (is_word & (alu_result_i[1:0] != 2'b00));

  // Reset gates the request so it drops in the same cycle.
  assign mem_op = instr_valid_i & (is_load | is_store)
                & (trap_i == NO_TRAP) & ~flush_i & ~rst_i;

  assign access_en = mem_op & ~misalign;
  assign mis_trap  = mem_op & misalign;

  always_comb begin
    wsel_c  = 4'b1111;
    wdata_c = alu_oper2_i;
    unique case (1'b1)
      (mem_oper_i == MEM_SB): begin
        wsel_c  = 4'b0001 << alu_result_i[1:0];
        wdata_c = {4{alu_oper2_i[7:0]}};
      end
      (mem_oper_i == MEM_SH): begin
        wsel_c  = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{alu_oper2_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    cap_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_c = access_en;
        if (access_en) begin
          if (dbus_ack_i) begin
            if (stall_i) begin
              cap_c   = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            stall_c = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req_c   = 1'b1;
        stall_c = ~dbus_ack_i;
        if (dbus_ack_i) begin
          cap_c   = 1'b1;
          state_d = (stall_i & ~flush_i) ? S_DONE : S_IDLE;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush_i | ~stall_i) state_d = S_IDLE;
      end
      S_DRAIN: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dbus_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request fields are latched so they stay stable until the ack.
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && access_en && !dbus_ack_i) begin
      we_q    <= is_store;
      addr_q  <= {alu_result_i[31:2], 2'b00};
      wsel_q  <= is_store ? wsel_c : 4'b1111;
      wdata_q <= wdata_c;
    end
    if (cap_c) rdata_q <= dbus_rdata_i;
  end

  always_comb begin
    if (state_q == S_IDLE) begin
      dbus_we_o    = is_store;
      dbus_addr_o  = {alu_result_i[31:2], 2'b00};
      dbus_wsel_o  = is_store ? wsel_c : 4'b1111;
      dbus_wdata_o = wdata_c;
    end else begin
      dbus_we_o    = we_q;
      dbus_addr_o  = addr_q;
      dbus_wsel_o  = wsel_q;
      dbus_wdata_o = wdata_q;
    end
  end

  assign dbus_req_o  = req_c;
  assign stall_req_o = stall_c;

  assign word    = (state_q == S_DONE) ? rdata_q : dbus_rdata_i;
  assign shifted = word >> {alu_result_i[1:0], 3'b000};

  always_comb begin
    load_val = word;
    unique case (mem_oper_i)
      MEM_LB:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LBU: load_val = {24'h0, shifted[7:0]};
      MEM_LH:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LHU: load_val = {16'h0, shifted[15:0]};
      default: load_val = word;
    endcase
  end

  always_comb begin
    rd_data_d  = is_load ? load_val : alu_result_i;
    trap_d     = trap_i;
    write_rd_d = write_rd_i;
    if (mis_trap) begin
      trap_d     = is_load ? LOAD_ADDR_MISALIGNED
                           : STORE_ADDR_MISALIGNED;
      write_rd_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q    <= 1'b0;
      write_rd_q <= 1'b0;
      csr_we_q   <= 1'b0;
      is_csr_q   <= 1'b0;
      trap_q     <= NO_TRAP;
    end else if (!stall_i) begin
      if (stall_c) begin
        valid_q    <= 1'b0;
        write_rd_q <= 1'b0;
        csr_we_q   <= 1'b0;
        is_csr_q   <= 1'b0;
        trap_q     <= NO_TRAP;
      end else begin
        valid_q     <= instr_valid_i;
        write_rd_q  <= write_rd_d;
        csr_we_q    <= csr_we_i;
        is_csr_q    <= is_csr_i;
        trap_q      <= trap_d;
        pc_q        <= pc_i;
        rd_data_q   <= rd_data_d;
        mem_addr_q  <= alu_result_i;
        csr_wdata_q <= csr_wdata_i;
        csr_waddr_q <= csr_waddr_i;
        rd_addr_q   <= rd_addr_i;
      end
    end
  end

  assign instr_valid_o = valid_q;
  assign write_rd_o    = write_rd_q;
  assign csr_we_o      = csr_we_q;
  assign is_csr_o      = is_csr_q;
  assign trap_o        = trap_q;
  assign pc_o          = pc_q;
  assign rd_data_o     = rd_data_q;
  assign mem_addr_o    = mem_addr_q;
  assign csr_wdata_o   = csr_wdata_q;
  assign csr_waddr_o   = csr_waddr_q;
  assign rd_addr_o     = rd_addr_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus a
// randomized sweep against an arithmetic reference model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_i = '0, alu_result_i = '0, alu_oper2_i = '0;
  mem_oper_t   mem_oper_i = MEM_NOP;
  logic [31:0] csr_wdata_i = '0;
  logic [11:0] csr_waddr_i = '0;
  logic        csr_we_i = 1'b0, is_csr_i = 1'b0;
  exc_t        trap_i = NO_TRAP;
  logic        instr_valid_i = 1'b0, write_rd_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic        stall_i = 1'b0, flush_i = 1'b0;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_wsel_o;
  logic        dbus_ack_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;
  logic        stall_req_o;
  logic [31:0] rd_data_o, mem_addr_o, csr_wdata_o, pc_o;
  logic [11:0] csr_waddr_o;
  logic        csr_we_o, is_csr_o, instr_valid_o, write_rd_o;
  exc_t        trap_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i),
    .alu_result_i(alu_result_i), .alu_oper2_i(alu_oper2_i),
    .mem_oper_i(mem_oper_i), .csr_wdata_i(csr_wdata_i),
    .csr_waddr_i(csr_waddr_i), .csr_we_i(csr_we_i),
    .is_csr_i(is_csr_i), .trap_i(trap_i),
    .instr_valid_i(instr_valid_i), .write_rd_i(write_rd_i),
    .rd_addr_i(rd_addr_i), .stall_i(stall_i), .flush_i(flush_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_wsel_o(dbus_wsel_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
    .dbus_rdata_i(dbus_rdata_i), .stall_req_o(stall_req_o),
    .rd_data_o(rd_data_o), .mem_addr_o(mem_addr_o),
    .csr_wdata_o(csr_wdata_o), .csr_waddr_o(csr_waddr_o),
    .csr_we_o(csr_we_o), .is_csr_o(is_csr_o), .trap_o(trap_o),
    .pc_o(pc_o), .instr_valid_o(instr_valid_o),
    .write_rd_o(write_rd_o), .rd_addr_o(rd_addr_o)
  );

  function automatic bit m_is_load(mem_oper_t op);
    return op == MEM_LB || op == MEM_LBU || op == MEM_LH
        || op == MEM_LHU || op == MEM_LW;
  endfunction

  function automatic bit m_mis(mem_oper_t op, logic [31:0] a);
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH)
      return (a % 2) != 0;
    if (op == MEM_LW || op == MEM_SW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(mem_oper_t op,
      logic [31:0] a, logic [31:0] w);
    logic [31:0] v;
    v = w / (32'd1 << (8 * (a % 4)));
    case (op)
      MEM_LBU: return v % 256;
      MEM_LHU: return v % 65536;
      MEM_LB: begin
        v = v % 256;
        return (v >= 128) ? v - 256 : v;
      end
      MEM_LH: begin
        v = v % 65536;
        return (v >= 32768) ? v - 65536 : v;
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_wsel(mem_oper_t op,
      logic [31:0] a);
    if (op == MEM_SB) return 4'(1 << (a % 4));
    if (op == MEM_SH) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(mem_oper_t op,
      logic [31:0] d);
    if (op == MEM_SB) return (d % 256) * 32'h0101_0101;
    if (op == MEM_SH) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(mem_oper_t op, logic [31:0] a,
      logic [31:0] d, logic wr);
    mem_oper_i    = op;
    alu_result_i  = a;
    alu_oper2_i   = d;
    instr_valid_i = 1'b1;
    write_rd_i    = wr;
    pc_i          = $urandom;
    rd_addr_i     = 5'($urandom);
  endtask

  task automatic set_nop();
    mem_oper_i    = MEM_NOP;
    instr_valid_i = 1'b0;
    write_rd_i    = 1'b0;
    csr_we_i      = 1'b0;
    is_csr_i      = 1'b0;
    dbus_ack_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_instr(MEM_LW, 32'h100, 0, 1'b1);
    csr_we_i = 1'b1;
    is_csr_i = 1'b1;
    #2;
    checks++;
    if (dbus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got=%b exp=0", dbus_req_o);
    end
    cyc();
    cyc();
    checks++;
    if (stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got=%b exp=0", stall_req_o);
    end
    checks++;
    if ({instr_valid_o, write_rd_o, csr_we_o, is_csr_o} !== 4'b0)
    begin
      errors++;
      $display("FAIL reset_bubble got=%b%b%b%b exp=0000",
               instr_valid_o, write_rd_o, csr_we_o, is_csr_o);
    end
    checks++;
    if (trap_o !== NO_TRAP) begin
      errors++;
      $display("FAIL reset_trap got=%0d exp=%0d", trap_o, NO_TRAP);
    end
    set_nop();
    rst_i = 1'b0;
    cyc();
  endtask

  task automatic test_lw_zero_wait();
    logic [31:0] pc;
    set_instr(MEM_LW, 32'h100, 0, 1'b1);
    pc = pc_i;
    csr_wdata_i = 32'h5555_AAAA;
    csr_waddr_i = 12'h341;
    csr_we_i = 1'b1;
    dbus_ack_i = 1'b1;
    dbus_rdata_i = 32'hDEAD_BEEF;
    #2;
    checks++;
    if ({dbus_req_o, stall_req_o, dbus_we_o} !== 3'b100) begin
      errors++;
      $display("FAIL lw0_ctrl got req=%b stall=%b we=%b exp 1/0/0",
               dbus_req_o, stall_req_o, dbus_we_o);
    end
    checks++;
    if (dbus_addr_o !== 32'h100 || dbus_wsel_o !== 4'hF) begin
      errors++;
      $display("FAIL lw0_addr got=%h/%h exp=00000100/f",
               dbus_addr_o, dbus_wsel_o);
    end
    cyc();
    checks++;
    if (rd_data_o !== 32'hDEAD_BEEF || write_rd_o !== 1'b1
        || instr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL lw0_result got=%h wr=%b v=%b exp=deadbeef/1/1",
               rd_data_o, write_rd_o, instr_valid_o);
    end
    checks++;
    if (pc_o !== pc || csr_wdata_o !== 32'h5555_AAAA
        || csr_waddr_o !== 12'h341 || csr_we_o !== 1'b1) begin
      errors++;
      $display("FAIL lw0_pass got pc=%h csr=%h/%h/%b exp pc=%h",
               pc_o, csr_wdata_o, csr_waddr_o, csr_we_o, pc);
    end
    set_nop();
  endtask

  task automatic test_lb_wait(mem_oper_t op, logic [31:0] exp);
    set_instr(op, 32'h103, 0, 1'b1);
    dbus_rdata_i = 32'h8011_2233;
    for (int k = 0; k < 4; k++) begin
      dbus_ack_i = (k == 3);
      #2;
      checks++;
      if (dbus_req_o !== 1'b1 || stall_req_o !== (k < 3)
          || dbus_addr_o !== 32'h100) begin
        errors++;
        $display("FAIL lbw_cyc%0d req=%b stall=%b addr=%h exp 1/%b/100",
                 k, dbus_req_o, stall_req_o, dbus_addr_o, k < 3);
      end
      cyc();
      checks++;
      if (k < 3 && instr_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL lbw_bubble%0d got v=%b exp=0", k, instr_valid_o);
      end else if (k == 3 && (rd_data_o !== exp
                   || instr_valid_o !== 1'b1)) begin
        errors++;
        $display("FAIL lbw_result got=%h v=%b exp=%h",
                 rd_data_o, instr_valid_o, exp);
      end
    end
    set_nop();
    #2;
    checks++;
    if (dbus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL lbw_idle got req=%b exp=0", dbus_req_o);
    end
    cyc();
  endtask

  task automatic test_store();
    set_instr(MEM_SH, 32'h202, 32'h1234_ABCD, 1'b0);
    dbus_ack_i = 1'b1;
    #2;
    checks++;
    if (dbus_we_o !== 1'b1 || dbus_addr_o !== 32'h200
        || dbus_wsel_o !== 4'b1100 || dbus_wdata_o !== 32'hABCD_ABCD)
    begin
      errors++;
      $display("FAIL sh got we=%b a=%h s=%b d=%h exp 1/200/1100/abcdabcd",
               dbus_we_o, dbus_addr_o, dbus_wsel_o, dbus_wdata_o);
    end
    cyc();
    set_nop();
  endtask

  task automatic test_misaligned();
    set_instr(MEM_LW, 32'h101, 0, 1'b1);
    #2;
    checks++;
    if (dbus_req_o !== 1'b0 || stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mis_req got req=%b stall=%b exp=0/0",
               dbus_req_o, stall_req_o);
    end
    cyc();
    checks++;
    if (trap_o !== LOAD_ADDR_MISALIGNED || mem_addr_o !== 32'h101
        || write_rd_o !== 1'b0) begin
      errors++;
      $display("FAIL mis_lw got trap=%0d a=%h wr=%b exp=%0d/101/0",
               trap_o, mem_addr_o, write_rd_o, LOAD_ADDR_MISALIGNED);
    end
    set_instr(MEM_SW, 32'h206, 32'h1, 1'b0);
    cyc();
    checks++;
    if (trap_o !== STORE_ADDR_MISALIGNED) begin
      errors++;
      $display("FAIL mis_sw got trap=%0d exp=%0d",
               trap_o, STORE_ADDR_MISALIGNED);
    end
    set_nop();
    cyc();
  endtask

  task automatic test_flush_wait();
    set_instr(MEM_LW, 32'h100, 0, 1'b1);
    dbus_ack_i = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      flush_i = (k == 0);
      dbus_ack_i = (k == 2);
      #2;
      checks++;
      if (dbus_req_o !== 1'b1 || stall_req_o !== 1'b1) begin
        errors++;
        $display("FAIL flush_cyc%0d req=%b stall=%b exp=1/1",
                 k, dbus_req_o, stall_req_o);
      end
      cyc();
      checks++;
      if (instr_valid_o !== 1'b0 || write_rd_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_bubble%0d got v=%b wr=%b exp=0/0",
                 k, instr_valid_o, write_rd_o);
      end
    end
    flush_i = 1'b0;
    set_instr(MEM_LW, 32'h108, 0, 1'b1);
    dbus_ack_i = 1'b1;
    dbus_rdata_i = 32'h0000_0011;
    #2;
    checks++;
    if (dbus_req_o !== 1'b1 || stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle req=%b stall=%b exp=1/0",
               dbus_req_o, stall_req_o);
    end
    cyc();
    checks++;
    if (rd_data_o !== 32'h11 || instr_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_next got=%h v=%b exp=00000011/1",
               rd_data_o, instr_valid_o);
    end
    set_nop();
  endtask

  task automatic test_done();
    set_instr(MEM_LW, 32'h104, 0, 1'b1);
    dbus_ack_i = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      stall_i = (k < 2);
      dbus_ack_i = (k == 0);
      dbus_rdata_i = (k == 0) ? 32'hCAFE_F00D : $urandom;
      #2;
      checks++;
      if (k > 0 && (dbus_req_o !== 1'b0 || stall_req_o !== 1'b0))
      begin
        errors++;
        $display("FAIL done_cyc%0d req=%b stall=%b exp=0/0",
                 k, dbus_req_o, stall_req_o);
      end else if (k == 0 && stall_req_o !== 1'b0) begin
        errors++;
        $display("FAIL done_ack stall=%b exp=0", stall_req_o);
      end
      cyc();
      checks++;
      if (k < 2 && instr_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL done_hold%0d v=%b exp=0", k, instr_valid_o);
      end else if (k == 2 && (rd_data_o !== 32'hCAFE_F00D
                   || instr_valid_o !== 1'b1)) begin
        errors++;
        $display("FAIL done_result got=%h v=%b exp=cafef00d/1",
                 rd_data_o, instr_valid_o);
      end
    end
    stall_i = 1'b0;
    set_nop();
    #2;
    checks++;
    if (dbus_req_o !== 1'b0) begin
      errors++;
      $display("FAIL done_noreq got req=%b exp=0", dbus_req_o);
    end
    cyc();
  endtask

  task automatic test_random();
    mem_oper_t ops [8] = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU,
                           MEM_LW, MEM_SB, MEM_SH, MEM_SW};
    mem_oper_t op;
    logic [31:0] a, d, w;
    bit ld, wr;
    int n;
    for (int it = 0; it < 60; it++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h1 & ~(32'(op == MEM_LW
             || op == MEM_SW) << 1);
      d  = $urandom;
      ld = m_is_load(op);
      wr = ld;
      n  = $urandom_range(0, 3);
      set_instr(op, a, d, wr);
      if (m_mis(op, a)) begin
        #2;
        checks++;
        if (dbus_req_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd_mis_req it=%0d req=%b exp=0",
                   it, dbus_req_o);
        end
        cyc();
        checks++;
        if (trap_o !== (ld ? LOAD_ADDR_MISALIGNED
                           : STORE_ADDR_MISALIGNED)
            || write_rd_o !== 1'b0 || mem_addr_o !== a) begin
          errors++;
          $display("FAIL rnd_mis it=%0d trap=%0d wr=%b a=%h exp a=%h",
                   it, trap_o, write_rd_o, mem_addr_o, a);
        end
        set_nop();
        continue;
      end
      for (int k = 0; k <= n; k++) begin
        dbus_ack_i = (k == n);
        w = $urandom;
        dbus_rdata_i = w;
        #2;
        checks++;
        if (dbus_req_o !== 1'b1 || stall_req_o !== (k < n)
            || dbus_we_o !== !ld || dbus_addr_o !== (a & ~32'h3)
            || dbus_wsel_o !== (ld ? 4'hF : m_wsel(op, a))
            || (!ld && dbus_wdata_o !== m_wdata(op, d))) begin
          errors++;
          $display("FAIL rnd_bus it=%0d k=%0d req=%b st=%b we=%b a=%h s=%h d=%h exp a=%h s=%h d=%h",
                   it, k, dbus_req_o, stall_req_o, dbus_we_o,
                   dbus_addr_o, dbus_wsel_o, dbus_wdata_o,
                   a & ~32'h3, ld ? 4'hF : m_wsel(op, a),
                   m_wdata(op, d));
        end
        cyc();
        checks++;
        if (k < n && instr_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd_bubble it=%0d k=%0d v=%b exp=0",
                   it, k, instr_valid_o);
        end else if (k == n && (instr_valid_o !== 1'b1
                     || write_rd_o !== wr
                     || rd_data_o !== (ld ? m_load(op, a, w) : a)))
        begin
          errors++;
          $display("FAIL rnd_result it=%0d op=%0d got=%h exp=%h v=%b",
                   it, op, rd_data_o, ld ? m_load(op, a, w) : a,
                   instr_valid_o);
        end
      end
      set_nop();
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_lw_zero_wait();
    test_lb_wait(MEM_LB, 32'hFFFF_FF80);
    test_lb_wait(MEM_LBU, 32'h0000_0080);
    test_store();
    test_misaligned();
    test_flush_wait();
    test_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
